// File: rtl/multiplicador_sinal_seq_if.sv
// Operand/result bus of the signed 6x6 sequential multiplier.
// The issuer drives inicio/a/b; the multiplier drives produto/pronto/ocupado and exposes its FSM state.
interface multiplicador_sinal_seq_if;
  logic        inicio;
  logic [5:0]  a;
  logic [5:0]  b;
  logic [11:0] produto;
  logic        pronto;
  logic        ocupado;
  logic [1:0]  estado;

  modport master (
    output inicio, a, b,
    input  produto, pronto, ocupado, estado
  );

  modport slave (
    input  inicio, a, b,
    output produto, pronto, ocupado, estado
  );
endinterface

// File: rtl/multiplicador_sinal_seq.sv
// Signed 6x6 -> 12-bit multiplier: magnitude conversion, six shift-and-add steps,
// then sign application. Fixed latency of 8 cycles from the accepting edge.
module multiplicador_sinal_seq (
  input  logic                              clk,
  input  logic                              reset,
  multiplicador_sinal_seq_if.slave          bus
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    MODULO = 2'd1,
    SOMA   = 2'd2,
    SINAL  = 2'd3
  } estado_t;

  estado_t     estado;
  logic [5:0]  ra;
  logic [5:0]  rb;
  logic        neg;
  logic [5:0]  ma;
  logic [5:0]  mb;
  logic [11:0] acc;
  logic [2:0]  k;
  logic [11:0] produto;
  logic        pronto;
  logic        ocupado;

  // Complement unit: -32 maps to 6'b100000, read as unsigned 32.
  function automatic logic [5:0] complemento(input logic [5:0] v, input logic sinal);
    return sinal ? (~v + 6'd1) : v;
  endfunction

  // Handshake: inicio is sampled only while idle (ocupado=0); the accepting edge
  // latches a/b and raises ocupado. Eight edges later pronto pulses for one cycle
  // on the same edge that ocupado falls and produto updates. inicio while busy is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado  <= OCIOSO;
      ra      <= 6'd0;
      rb      <= 6'd0;
      neg     <= 1'b0;
      ma      <= 6'd0;
      mb      <= 6'd0;
      acc     <= 12'd0;
      k       <= 3'd0;
      produto <= 12'd0;
      pronto  <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (bus.inicio) begin
            ra      <= bus.a;
            rb      <= bus.b;
            neg     <= bus.a[5] ^ bus.b[5];
            ocupado <= 1'b1;
            estado  <= MODULO;
          end
        end
        MODULO: begin
          ma     <= complemento(ra, ra[5]);
          mb     <= complemento(rb, rb[5]);
          acc    <= 12'd0;
          k      <= 3'd0;
          estado <= SOMA;
        end
        SOMA: begin
          if (mb[0]) begin
            acc <= acc + ({6'd0, ma} << k);
          end
          mb <= mb >> 1;
          k  <= k + 3'd1;
          if (k == 3'd5) begin
            estado <= SINAL;
          end
        end
        SINAL: begin
          produto <= neg ? (~acc + 12'd1) : acc;
          pronto  <= 1'b1;
          ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign bus.produto = produto;
  assign bus.pronto  = pronto;
  assign bus.ocupado = ocupado;
  assign bus.estado  = estado;

endmodule

// File: tb/tb_multiplicador_sinal_seq.sv
// Self-checking bench for multiplicador_sinal_seq: directed sign/extreme cases,
// busy-start rejection, reset mid-operation, back-to-back and random operands.
module tb_multiplicador_sinal_seq;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  multiplicador_sinal_seq_if bus ();

  multiplicador_sinal_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact signed product reduced mod 2^12.
  function automatic logic [11:0] ref_prod(input logic [5:0] x, input logic [5:0] y);
    int sx;
    int sy;
    int p;
    sx = int'($signed(x));
    sy = int'($signed(y));
    p  = sx * sy;
    return p[11:0];
  endfunction

  // Driver: issue one operation and observe it until pronto (or timeout).
  // lat = edges from accepting edge to the pronto edge (-1 on timeout).
  task automatic do_op(input logic [5:0] xa, input logic [5:0] xb, input bit imediato,
                       output int lat, output logic [11:0] p, output int busy,
                       output bit prod_changed);
    logic [11:0] p0;
    if (!imediato) @(negedge clk);
    bus.inicio = 1'b1;
    bus.a      = xa;
    bus.b      = xb;
    p0         = bus.produto;
    @(posedge clk);
    #1;
    bus.inicio   = 1'b0;
    bus.a        = 6'($urandom_range(0, 63));
    bus.b        = 6'($urandom_range(0, 63));
    busy         = bus.ocupado ? 1 : 0;
    lat          = -1;
    p            = 12'hxxx;
    prod_changed = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.pronto) begin
        lat = i;
        p   = bus.produto;
        break;
      end
      if (bus.ocupado) busy++;
      if (bus.produto !== p0) prod_changed = 1'b1;
    end
  endtask

  task automatic check_op(input string name, input logic [5:0] xa, input logic [5:0] xb,
                          input bit imediato);
    int          lat;
    int          busy;
    logic [11:0] p;
    logic [11:0] exp;
    bit          chg;
    exp = ref_prod(xa, xb);
    do_op(xa, xb, imediato, lat, p, busy, chg);
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL %s latency: got %0d want 8", name, lat);
    end
    checks++;
    if (p !== exp) begin
      failures++;
      $display("FAIL %s produto: a=%0d b=%0d got %h want %h", name,
               $signed(xa), $signed(xb), p, exp);
    end
    checks++;
    if (busy !== 8 || bus.ocupado !== 1'b0) begin
      failures++;
      $display("FAIL %s ocupado: busy cycles %0d (want 8), ocupado at pronto %b (want 0)",
               name, busy, bus.ocupado);
    end
    checks++;
    if (chg) begin
      failures++;
      $display("FAIL %s produto_stable: produto changed before completion (got change, want none)", name);
    end
  endtask

  task automatic test_reset();
    bus.inicio = 1'b1;
    bus.a      = 6'd5;
    bus.b      = 6'd5;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.produto !== 12'h000 || bus.pronto !== 1'b0 || bus.ocupado !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: produto=%h pronto=%b ocupado=%b want 000/0/0",
               bus.produto, bus.pronto, bus.ocupado);
    end
    bus.inicio = 1'b0;
    reset      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.ocupado !== 1'b0 || bus.pronto !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_start: ocupado=%b pronto=%b want 0/0", bus.ocupado, bus.pronto);
    end
  endtask

  task automatic test_basic();
    check_op("basic_5x3", 6'd5, 6'd3, 1'b0);
    checks++;
    if (bus.produto !== 12'h00F) begin
      failures++;
      $display("FAIL basic_const: got %h want 00f", bus.produto);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.pronto !== 1'b0 || bus.produto !== 12'h00F) begin
      failures++;
      $display("FAIL pronto_one_cycle: pronto=%b produto=%h want 0/00f", bus.pronto, bus.produto);
    end
  endtask

  task automatic test_signs();
    logic [5:0] ta[4] = '{6'h39, 6'h20, 6'd31, 6'd0};
    logic [5:0] tb[4] = '{6'd6, 6'h20, 6'h20, 6'h3F};
    logic [11:0] te[4] = '{12'hFD6, 12'h400, 12'hC20, 12'h000};
    for (int i = 0; i < 4; i++) begin
      check_op("sign_case", ta[i], tb[i], 1'b0);
      checks++;
      if (bus.produto !== te[i]) begin
        failures++;
        $display("FAIL sign_const[%0d]: got %h want %h", i, bus.produto, te[i]);
      end
    end
  endtask

  task automatic test_busy_start();
    int          npronto;
    logic [11:0] p;
    @(negedge clk);
    bus.inicio = 1'b1;
    bus.a      = 6'd2;
    bus.b      = 6'd2;
    @(posedge clk);
    #1;
    bus.inicio = 1'b0;
    npronto    = 0;
    p          = 12'hxxx;
    for (int i = 1; i <= 24; i++) begin
      if (i == 3) begin
        bus.inicio = 1'b1;
        bus.a      = 6'd9;
        bus.b      = 6'd9;
      end else begin
        bus.inicio = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.pronto) begin
        npronto++;
        p = bus.produto;
      end
    end
    checks++;
    if (npronto !== 1 || p !== 12'h004) begin
      failures++;
      $display("FAIL busy_start: pronto count %0d produto %h want 1/004", npronto, p);
    end
    checks++;
    if (bus.ocupado !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_idle: ocupado=%b want 0", bus.ocupado);
    end
  endtask

  task automatic test_reset_mid();
    int npronto;
    @(negedge clk);
    bus.inicio = 1'b1;
    bus.a      = 6'd10;
    bus.b      = 6'd10;
    @(posedge clk);
    #1;
    bus.inicio = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (bus.ocupado !== 1'b0 || bus.pronto !== 1'b0 || bus.produto !== 12'h000) begin
      failures++;
      $display("FAIL reset_mid: ocupado=%b pronto=%b produto=%h want 0/0/000",
               bus.ocupado, bus.pronto, bus.produto);
    end
    npronto = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.pronto) npronto++;
    end
    checks++;
    if (npronto !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_pronto: got %0d pulses want 0", npronto);
    end
    check_op("after_reset_3x-3", 6'd3, 6'h3D, 1'b0);
    checks++;
    if (bus.produto !== 12'hFF7) begin
      failures++;
      $display("FAIL after_reset_const: got %h want ff7", bus.produto);
    end
  endtask

  task automatic test_back_to_back();
    check_op("b2b_first", 6'd7, 6'h3B, 1'b0);
    check_op("b2b_second", 6'h3F, 6'h3F, 1'b1);
    checks++;
    if (bus.produto !== 12'h001) begin
      failures++;
      $display("FAIL b2b_const: got %h want 001", bus.produto);
    end
  endtask

  task automatic test_random();
    logic [5:0] xa;
    logic [5:0] xb;
    for (int i = 0; i < 40; i++) begin
      xa = 6'($urandom_range(0, 63));
      xb = 6'($urandom_range(0, 63));
      check_op("random", xa, xb, ($urandom_range(0, 1) == 1));
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    bus.inicio = 1'b0;
    bus.a      = 6'd0;
    bus.b      = 6'd0;
    test_reset();
    test_basic();
    test_signs();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
